mem_wait_responder: RTL and testbench
=====================================

Name: mem_wait_responder

Overview:
- Unified instruction/data memory responder for the multicycle CPU.
- Serves the word read/write requests the control FSM issues: instruction fetch via ir_write/i_or_d, data access via mem_write.
- Adds a configurable wait-state latency and a single-cycle ready handshake, so the control FSM can stall on slow memory.
- Sits between the datapath address/write-data muxes and the IR/MDR registers.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words).
- WAIT_CYCLES, 2, busy cycles inserted between request acceptance and ready; legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present; requester holds it and all request fields stable until ready.
- req_write  input  1  1 = write, 0 = read.
- addr  input  32  byte address; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- wdata  input  32  write data.
- rdata  output  32  read data; valid in the ready cycle of a read; held until the next read completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.
- err  output  1  out-of-range flag; valid only with ready.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, wait counter=0.
  - ready=0, err=0, rdata=0, busy=0.
  - Memory array is not cleared.
- Reset mid-operation: aborts immediately. A write not yet committed is discarded. No ready pulse is issued for the aborted request.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If req_valid=1, capture req_write, word index, range check and wdata into internal registers.
  - Go to BUSY with counter=WAIT_CYCLES-1, or go directly to DONE when WAIT_CYCLES=0.
  - Otherwise stay in IDLE.
- BUSY:
  - Decrement the counter each cycle.
  - When counter==0, go to DONE.
  - Inputs are not re-sampled in BUSY; only the captured values are used.
- Transition into DONE:
  - Read: rdata loads mem[index].
  - Write: mem[index] <= captured wdata at this same edge.
  - Out-of-range request: no memory update, rdata loads 0, err set.
- DONE:
  - ready=1 for exactly one cycle; err is valid in this cycle.
  - Next state is always IDLE.
  - req_valid seen in the DONE cycle is ignored.
- Latency: if req_valid is first seen high in IDLE at cycle 0, ready is high in cycle WAIT_CYCLES+1.
- Back-to-back: a held req_valid is accepted again in the IDLE cycle after DONE. Throughput is one request per WAIT_CYCLES+2 cycles.
- Range check: the request is out of range if any of addr[31:DEPTH_LOG2+2] is nonzero.
- Outputs in IDLE and BUSY: ready=0, err=0.
- rdata is unchanged by writes and by out-of-range writes.
- Read-after-write to the same word: the later read returns the new data (the write is committed before the next acceptance).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 with WAIT_CYCLES=2 -> ready=1 exactly in cycle 3 after acceptance; busy high in cycles 1..3; err=0.
- Read addr 0x10 immediately after that write -> ready in cycle 3 with rdata=0xDEADBEEF. Then read addr 0x13 -> same word, rdata=0xDEADBEEF.
- Write to addr 0x00000400 (DEPTH_LOG2=8, out of range) -> ready with err=1; a subsequent read of addr 0x000 returns its prior contents; rdata=0 for an out-of-range read.
- Hold req_valid high continuously on alternating reads of 0x0 and 0x4 -> ready pulses every 4 cycles, never two consecutive cycles high.
- Start a write of 0x12345678 to 0x20, assert reset=0 during BUSY -> no ready pulse; busy=0, rdata=0 after reset; a later read of 0x20 does not return 0x12345678 (pre-loaded with 0 beforehand).
- Instance with WAIT_CYCLES=0: read request in cycle 0 -> ready in cycle 1; busy high only in cycle 1.

Source files
------------

// File: rtl/mem_wait_responder.sv
// Word-addressed memory responder that adds a fixed number of wait states and
// signals completion with a one-cycle ready pulse.
module mem_wait_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for req_valid; captures the request on acceptance
  // BUSY  | counting down wait states using only the captured request
  // DONE  | ready pulse cycle; err valid; always returns to IDLE
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            state, state_next;
  logic [3:0]            cnt;
  logic                  cap_write, cap_oor;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_wdata;
  logic [31:0]           mem [DEPTH];

  logic                  req_oor;
  logic                  op_write, op_oor;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [31:0]           op_wdata;
  logic                  enter_done;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign req_oor = |addr[31:DEPTH_LOG2+2];

  // With zero wait states the commit happens on the accepting edge, so the
  // live request fields are used there instead of the captured copies.
  always_comb begin
    op_write = cap_write;
    op_oor   = cap_oor;
    op_idx   = cap_idx;
    op_wdata = cap_wdata;
    if (state == IDLE) begin
      op_write = req_write;
      op_oor   = req_oor;
      op_idx   = addr[DEPTH_LOG2+1:2];
      op_wdata = wdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_done = (state_next == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      busy      <= 1'b0;
      cap_write <= 1'b0;
      cap_oor   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      ready <= enter_done;
      err   <= enter_done && op_oor;
      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_oor   <= req_oor;
        cap_idx   <= addr[DEPTH_LOG2+1:2];
        cap_wdata <= wdata;
        cnt       <= CNT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !op_write)
        rdata <= op_oor ? 32'd0 : mem[op_idx];
    end
  end

  // Memory is not cleared by reset; an in-flight write never commits under reset.
  always_ff @(posedge clk) begin
    if (reset && enter_done && op_write && !op_oor)
      mem[op_idx] <= op_wdata;
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder with a queue scoreboard; covers a
// WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_wait_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] addr, wdata, rdata;
  logic        ready, busy, err;

  logic        req_valid0, req_write0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, busy0, err0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [256];
  logic [31:0] last_rdata;

  mem_wait_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mem_wait_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: update the model and queue what the completion must show.
  task automatic push_exp(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic oor;
    logic [7:0] idx;
    oor = |a[31:10];
    idx = a[9:2];
    if (wr) begin
      if (!oor) model[idx] = d;
      e.rdata = last_rdata;
    end else begin
      e.rdata = oor ? 32'd0 : model[idx];
      last_rdata = e.rdata;
    end
    e.err = oor;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rdata, e.rdata);
      check({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; addr = a; wdata = d;
    push_exp(wr, a, d);
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (ready) begin
        got = 1;
        check({tag, "_latency"}, n, W + 1);
        pop_check(tag);
        req_valid = 1'b0;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, ready}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int last_c, pulses;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; addr = '0; wdata = '0;
    req_valid0 = 1'b0; req_write0 = 1'b0; addr0 = '0; wdata0 = '0;
    last_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b1;

    do_req("wr10", 1'b1, 32'h10, 32'hDEADBEEF);
    do_req("rd10", 1'b0, 32'h10, 32'h0);
    do_req("rd13", 1'b0, 32'h13, 32'h0);

    do_req("wr00", 1'b1, 32'h0, 32'hA5A50000);
    do_req("wr04", 1'b1, 32'h4, 32'h44444444);
    do_req("wr_oor", 1'b1, 32'h400, 32'hBAD0BAD0);
    do_req("rd00", 1'b0, 32'h0, 32'h0);
    do_req("rd_oor", 1'b0, 32'h800, 32'h0);

    // Held req_valid on alternating reads: one pulse per W+2 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; addr = 32'h0;
    push_exp(1'b0, 32'h0, 32'h0);
    last_c = 0; pulses = 0;
    for (int c = 1; c <= 30 && pulses < 4; c++) begin
      @(negedge clk);
      if (ready) begin
        pop_check("b2b");
        if (pulses == 0) check("b2b_first_lat", c, W + 1);
        else             check("b2b_gap", c - last_c, W + 2);
        last_c = c;
        pulses++;
        if (pulses < 4) begin
          addr = (addr == 32'h0) ? 32'h4 : 32'h0;
          push_exp(1'b0, addr, 32'h0);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_pulses", pulses, 4);
    req_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);

    // Reset during BUSY discards the write and produces no ready.
    do_req("wr20_zero", 1'b1, 32'h20, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    reset = 1'b1;
    last_rdata = 32'd0;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (ready) seen++;
      end
      check("abort_no_ready", seen, 0);
    end
    do_req("rd20", 1'b0, 32'h20, 32'h0);

    // Zero-wait instance.
    @(negedge clk);
    req_valid0 = 1'b1; req_write0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_wr_ready", {31'd0, ready0}, 32'd1);
    check("w0_wr_busy",  {31'd0, busy0},  32'd1);
    check("w0_wr_err",   {31'd0, err0},   32'd0);
    req_valid0 = 1'b0;
    @(negedge clk);
    check("w0_wr_ready_after", {31'd0, ready0}, 32'd0);
    check("w0_wr_busy_after",  {31'd0, busy0},  32'd0);
    req_valid0 = 1'b1; req_write0 = 1'b0; addr0 = 32'h8;
    @(negedge clk);
    check("w0_rd_ready", {31'd0, ready0}, 32'd1);
    check("w0_rd_busy",  {31'd0, busy0},  32'd1);
    check("w0_rd_rdata", rdata0, 32'hCAFEF00D);
    req_valid0 = 1'b0;
    @(negedge clk);
    check("w0_rd_busy_after", {31'd0, busy0}, 32'd0);
    check("w0_rd_hold", rdata0, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
